fp_cmp_stream: RTL and testbench

FP_CMP_STREAM -- requirements
Module: fp_cmp_stream

---
 rtl/fp_cmp_stream.sv | 191 +++++++++++++++++++
 tb/tb_fp_cmp_stream.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/fp_cmp_stream.sv
// Streaming floating-point comparator with per-packet MAX/MIN reduction.
// Two pipeline stages (S1 decode/compare, S2 output) that advance together
// whenever the output register is free or being drained.
module fp_cmp_stream #(
  parameter int unsigned EXP_W = 5,
  parameter int unsigned MAN_W = 10,
  parameter int unsigned IDX_W = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [EXP_W+MAN_W:0]   in_a,
  input  logic [EXP_W+MAN_W:0]   in_b,
  input  logic                   in_last,
  input  logic [1:0]             mode,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic                   out_ge,
  output logic                   out_eq,
  output logic                   out_nan,
  output logic [EXP_W+MAN_W:0]   out_res,
  output logic [IDX_W-1:0]       out_idx
);

  localparam int unsigned W = 1 + EXP_W + MAN_W;

  localparam logic [1:0] MODE_MAX = 2'd1;
  localparam logic [1:0] MODE_MIN = 2'd2;

  // Quiet NaN returned when a reduction packet holds no ordered value
  localparam logic [W-1:0] QNAN = {1'b0, {EXP_W{1'b1}}, (MAN_W'(1) << (MAN_W - 1))};

  typedef enum logic {S_IDLE, S_PKT} pkt_state_e;

  pkt_state_e         state_q, state_d;
  logic [1:0]         mode_q, mode_eff_c;
  logic [IDX_W-1:0]   cnt_q;

  logic [W-1:0]       acc_val_q;
  logic [IDX_W-1:0]   acc_idx_q;
  logic               acc_has_q;
  logic               acc_nan_q;

  logic               s1_valid_q, s1_ge_q, s1_eq_q, s1_nan_q;
  logic [W-1:0]       s1_res_q;
  logic [IDX_W-1:0]   s1_idx_q;

  logic               s1_valid_d, s1_ge_d, s1_eq_d, s1_nan_d;
  logic [W-1:0]       s1_res_d;
  logic [IDX_W-1:0]   s1_idx_d;

  logic               fire_c, is_red_c, a_nan_c, b_nan_c, take_c;
  logic               beat_ge_c, beat_eq_c, better_c;
  logic [W-1:0]       nxt_val_c;
  logic [IDX_W-1:0]   nxt_idx_c;
  logic               nxt_has_c, nxt_nan_c;

  function automatic logic f_is_nan(input logic [W-1:0] x);
    return (&x[W-2:MAN_W]) && (|x[MAN_W-1:0]);
  endfunction

  function automatic logic f_is_zero(input logic [W-1:0] x);
    return ~|x[W-2:0];
  endfunction

  // Sign-magnitude mapped onto an unsigned key that sorts numerically
  function automatic logic [W-1:0] f_key(input logic [W-1:0] x);
    return x[W-1] ? ~x : {1'b1, x[W-2:0]};
  endfunction

  function automatic logic f_ge(input logic [W-1:0] a, input logic [W-1:0] b);
    return (f_key(a) >= f_key(b)) || (f_is_zero(a) && f_is_zero(b));
  endfunction

  function automatic logic f_eq(input logic [W-1:0] a, input logic [W-1:0] b);
    return (a == b) || (f_is_zero(a) && f_is_zero(b));
  endfunction

  // Every stage moves together whenever the output slot can take a new value
  assign in_ready = !out_valid || out_ready;
  assign fire_c   = in_valid && in_ready;

  // Packet tracker: mode is taken from the port only on a packet's first beat
  always_comb begin
    state_d    = state_q;
    mode_eff_c = mode_q;
    if (state_q == S_IDLE) mode_eff_c = mode;
    if (fire_c) state_d = in_last ? S_IDLE : S_PKT;
  end

  // Packet state, latched mode and beat counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      mode_q  <= 2'd0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      if (fire_c) begin
        mode_q <= mode_eff_c;
        cnt_q  <= in_last ? '0 : cnt_q + IDX_W'(1);
      end
    end
  end

  // Compare and reduction-merge logic feeding S1
  always_comb begin
    is_red_c  = (mode_eff_c == MODE_MAX) || (mode_eff_c == MODE_MIN);
    a_nan_c   = f_is_nan(in_a);
    b_nan_c   = f_is_nan(in_b);
    beat_ge_c = f_ge(in_a, acc_val_q);
    beat_eq_c = f_eq(in_a, acc_val_q);
    // Strict improvement only, so ties keep the earlier beat
    better_c  = (mode_eff_c == MODE_MAX) ? (beat_ge_c && !beat_eq_c) : !beat_ge_c;
    take_c    = !a_nan_c && (!acc_has_q || better_c);
    nxt_val_c = take_c ? in_a : acc_val_q;
    nxt_idx_c = take_c ? cnt_q : acc_idx_q;
    nxt_has_c = acc_has_q || !a_nan_c;
    nxt_nan_c = acc_nan_q || a_nan_c;

    s1_valid_d = fire_c && (!is_red_c || in_last);
    if (is_red_c) begin
      s1_ge_d  = 1'b1;
      s1_eq_d  = 1'b0;
      s1_nan_d = nxt_nan_c;
      s1_res_d = nxt_has_c ? nxt_val_c : QNAN;
      s1_idx_d = nxt_has_c ? nxt_idx_c : '0;
    end else begin
      s1_nan_d = a_nan_c || b_nan_c;
      s1_ge_d  = !s1_nan_d && f_ge(in_a, in_b);
      s1_eq_d  = !s1_nan_d && f_eq(in_a, in_b);
      s1_res_d = in_a;
      s1_idx_d = cnt_q;
    end
  end

  // Reduction accumulator; cleared at every packet boundary
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_val_q <= '0;
      acc_idx_q <= '0;
      acc_has_q <= 1'b0;
      acc_nan_q <= 1'b0;
    end else if (fire_c) begin
      if (in_last) begin
        acc_val_q <= '0;
        acc_idx_q <= '0;
        acc_has_q <= 1'b0;
        acc_nan_q <= 1'b0;
      end else if (is_red_c) begin
        acc_val_q <= nxt_val_c;
        acc_idx_q <= nxt_idx_c;
        acc_has_q <= nxt_has_c;
        acc_nan_q <= nxt_nan_c;
      end
    end
  end

  // S1 and S2 registers; both hold while the output is stalled
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q <= 1'b0;
      s1_ge_q    <= 1'b0;
      s1_eq_q    <= 1'b0;
      s1_nan_q   <= 1'b0;
      s1_res_q   <= '0;
      s1_idx_q   <= '0;
      out_valid  <= 1'b0;
      out_ge     <= 1'b0;
      out_eq     <= 1'b0;
      out_nan    <= 1'b0;
      out_res    <= '0;
      out_idx    <= '0;
    end else if (in_ready) begin
      s1_valid_q <= s1_valid_d;
      s1_ge_q    <= s1_ge_d;
      s1_eq_q    <= s1_eq_d;
      s1_nan_q   <= s1_nan_d;
      s1_res_q   <= s1_res_d;
      s1_idx_q   <= s1_idx_d;
      out_valid  <= s1_valid_q;
      out_ge     <= s1_ge_q;
      out_eq     <= s1_eq_q;
      out_nan    <= s1_nan_q;
      out_res    <= s1_res_q;
      out_idx    <= s1_idx_q;
    end
  end

endmodule

// File: tb/tb_fp_cmp_stream.sv
// Directed bench for fp_cmp_stream with half-precision operands.
module tb_fp_cmp_stream;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_a;
  logic [15:0] in_b;
  logic        in_last;
  logic [1:0]  mode;
  logic        out_valid;
  logic        out_ready;
  logic        out_ge;
  logic        out_eq;
  logic        out_nan;
  logic [15:0] out_res;
  logic [7:0]  out_idx;

  int checks = 0;
  int errors = 0;

  fp_cmp_stream #(.EXP_W(5), .MAN_W(10), .IDX_W(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_last   (in_last),
    .mode      (mode),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_ge    (out_ge),
    .out_eq    (out_eq),
    .out_nan   (out_nan),
    .out_res   (out_res),
    .out_idx   (out_idx)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one clock; drive and sample 1 time unit after the rising edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Present one beat for exactly one clock edge
  task automatic beat(input logic [15:0] a, input logic [15:0] b,
                      input logic last, input logic [1:0] m);
    in_valid = 1'b1;
    in_a     = a;
    in_b     = b;
    in_last  = last;
    mode     = m;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic chk_out(input string tag, input logic v, input logic ge, input logic eq,
                         input logic nan, input logic [15:0] res, input logic [7:0] idx);
    chk({tag, ".valid"}, 32'(out_valid), 32'(v));
    chk({tag, ".ge"},    32'(out_ge),    32'(ge));
    chk({tag, ".eq"},    32'(out_eq),    32'(eq));
    chk({tag, ".nan"},   32'(out_nan),   32'(nan));
    chk({tag, ".res"},   32'(out_res),   32'(res));
    chk({tag, ".idx"},   32'(out_idx),   32'(idx));
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; in_a = '0; in_b = '0;
    in_last = 1'b0; mode = 2'd0; out_ready = 1'b1;
    tick(); tick();
    chk_out("reset", 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 8'd0);
    rst_n = 1'b1;
    tick();
    chk("reset.in_ready", 32'(in_ready), 32'd1);

    // CMP 2.0 vs 1.0
    beat(16'h4000, 16'h3C00, 1'b1, 2'd0);
    tick();
    chk_out("cmp_gt", 1'b1, 1'b1, 1'b0, 1'b0, 16'h4000, 8'd0);
    tick();
    chk("cmp_gt.drain", 32'(out_valid), 32'd0);

    // CMP -0 vs +0, then NaN vs 1.0 (second beat indexed 1)
    beat(16'h8000, 16'h0000, 1'b0, 2'd0);
    beat(16'h7E00, 16'h3C00, 1'b1, 2'd0);
    chk_out("cmp_zero", 1'b1, 1'b1, 1'b1, 1'b0, 16'h8000, 8'd0);
    tick();
    chk_out("cmp_nan", 1'b1, 1'b0, 1'b0, 1'b1, 16'h7E00, 8'd1);
    tick();

    // CMP -inf vs -1.0 and mode 3 behaving as CMP
    beat(16'hFC00, 16'hBC00, 1'b1, 2'd3);
    tick();
    chk_out("cmp_ninf", 1'b1, 1'b0, 1'b0, 1'b0, 16'hFC00, 8'd0);
    tick();

    // MAX packet -1, +inf, 1 -> +inf at index 1
    beat(16'hBC00, 16'h0000, 1'b0, 2'd1);
    beat(16'h7C00, 16'h0000, 1'b0, 2'd1);
    beat(16'h3C00, 16'h0000, 1'b1, 2'd1);
    chk("max.no_partial", 32'(out_valid), 32'd0);
    tick();
    chk_out("max", 1'b1, 1'b1, 1'b0, 1'b0, 16'h7C00, 8'd1);
    tick();
    chk("max.single_out", 32'(out_valid), 32'd0);

    // MIN packet with mid-packet mode changes, then all-NaN packet back-to-back
    beat(16'h3C00, 16'h0000, 1'b0, 2'd2);
    beat(16'h7E00, 16'h0000, 1'b0, 2'd0);
    beat(16'h3C00, 16'h0000, 1'b1, 2'd0);
    beat(16'h7E00, 16'h0000, 1'b0, 2'd2);
    chk_out("min", 1'b1, 1'b1, 1'b0, 1'b1, 16'h3C00, 8'd0);
    beat(16'hFC01, 16'h0000, 1'b1, 2'd2);
    chk("allnan.no_partial", 32'(out_valid), 32'd0);
    tick();
    chk_out("allnan", 1'b1, 1'b1, 1'b0, 1'b1, 16'h7E00, 8'd0);
    tick();

    // MAX -0 then +0: the tie keeps the earlier beat
    beat(16'h8000, 16'h0000, 1'b0, 2'd1);
    beat(16'h0000, 16'h0000, 1'b1, 2'd1);
    tick();
    chk("zero_tie.res", 32'(out_res), 32'h8000);
    chk("zero_tie.idx", 32'(out_idx), 32'd0);
    tick();

    // Single-beat MIN packet
    beat(16'h4400, 16'h0000, 1'b1, 2'd2);
    tick();
    chk_out("single", 1'b1, 1'b1, 1'b0, 1'b0, 16'h4400, 8'd0);
    tick();

    // Backpressure: three stalled cycles, then everything drains in order
    out_ready = 1'b0;
    beat(16'h3C00, 16'h4000, 1'b0, 2'd0);
    beat(16'h4000, 16'h4000, 1'b0, 2'd0);
    in_valid = 1'b1; in_a = 16'hC000; in_b = 16'h3C00; in_last = 1'b1; mode = 2'd0;
    chk("stall.in_ready", 32'(in_ready), 32'd0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("stall.hold_ready", 32'(in_ready), 32'd0);
      chk_out("stall.hold", 1'b1, 1'b0, 1'b0, 1'b0, 16'h3C00, 8'd0);
    end
    out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    chk_out("stall.b", 1'b1, 1'b1, 1'b1, 1'b0, 16'h4000, 8'd1);
    tick();
    chk_out("stall.c", 1'b1, 1'b0, 1'b0, 1'b0, 16'hC000, 8'd2);
    tick();
    chk("stall.drain", 32'(out_valid), 32'd0);

    // Reset in the middle of a MAX packet discards the partial reduction
    beat(16'h4400, 16'h0000, 1'b0, 2'd1);
    beat(16'h4800, 16'h0000, 1'b0, 2'd1);
    rst_n = 1'b0;
    #1;
    chk_out("midrst", 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 8'd0);
    chk("midrst.in_ready", 32'(in_ready), 32'd1);
    tick();
    rst_n = 1'b1;
    tick();
    beat(16'h4000, 16'h0000, 1'b1, 2'd1);
    tick();
    chk_out("after_rst", 1'b1, 1'b1, 1'b0, 1'b0, 16'h4000, 8'd0);
    tick();
    chk("after_rst.drain", 32'(out_valid), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
